// File: rtl/load_store_mult_sequencer.sv
// load_store_mult_sequencer
//   Micro-op sequencer for Thumb LDM/STM/PUSH/POP. When a start is accepted it
//   walks the register list from the lowest set bit to the highest. It issues one
//   register transfer per cycle, and each transfer carries the byte offset
//   4 * (transfers already done). Fetch/decode is stalled until the last uop.
//
//   Optional feature macro: LSM_BASE_WRITEBACK_EN
//     defined   -> a base write-back cycle (WB) follows the last uop. It is
//                  suppressed for a load whose list contains the base register,
//                  because the loaded value wins.
//     undefined -> no WB state; the wb_* outputs are tied to 0.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          asynchronous, active-high reset
//   start_i          decoded LDM/STM valid (sampled only while idle)
//   is_load_i        1 = LDM/POP, 0 = STM/PUSH
//   reg_list_i       register list (r0..r7)
//   base_reg_i       base register number
//   hold_i           downstream hold; freezes the sequencer
//   busy_o           sequencer not idle
//   stall_pipeline_o hold fetch/decode (combinational)
//   uop_valid_o      a register transfer is presented this cycle
//   uop_reg_addr_o   register being transferred
//   uop_offset_o     byte offset from base
//   mem_write_en_o   store transfer
//   reg_write_en_o   load transfer
//   wb_valid_o       base write-back cycle
//   wb_reg_o         base register for write-back
//   wb_offset_o      total bytes transferred
//   done_o           one-cycle pulse at sequence completion
module load_store_mult_sequencer #(
  parameter int REG_LIST_W = 8,
  parameter int REG_ADDR_W = 4,
  parameter int OFFSET_W   = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  is_load_i,
  input  logic [REG_LIST_W-1:0] reg_list_i,
  input  logic [2:0]            base_reg_i,
  input  logic                  hold_i,
  output logic                  busy_o,
  output logic                  stall_pipeline_o,
  output logic                  uop_valid_o,
  output logic [REG_ADDR_W-1:0] uop_reg_addr_o,
  output logic [OFFSET_W-1:0]   uop_offset_o,
  output logic                  mem_write_en_o,
  output logic                  reg_write_en_o,
  output logic                  wb_valid_o,
  output logic [2:0]            wb_reg_o,
  output logic [OFFSET_W-1:0]   wb_offset_o,
  output logic                  done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] CNT_MAX = 4'(REG_LIST_W);

  logic [1:0]            state_reg, state_next;
  logic [REG_LIST_W-1:0] mask_reg, mask_next;
  logic [3:0]            count_reg, count_next;
  logic                  load_reg;
  logic [2:0]            base_reg;

  logic [REG_ADDR_W-1:0] low_idx;
  logic                  mask_last;
  logic                  wb_pending;
  logic [OFFSET_W-1:0]   count_bytes;
  logic                  in_xfer;
  logic                  accept;

  assign in_xfer     = (state_reg == ST_XFER);
  assign accept      = (state_reg == ST_IDLE) && start_i;
  assign count_bytes = OFFSET_W'({count_reg, 2'b00});

  // Exactly one bit left in the mask means the current uop is the final one.
  assign mask_last = ((mask_reg & (mask_reg - REG_LIST_W'(1))) == '0);

  // Index of the lowest set bit in the remaining mask. The loop scans downward
  // so that the last match written is the lowest bit.
  always_comb begin
    low_idx = '0;
    for (int i = REG_LIST_W - 1; i >= 0; i--) begin
      if (mask_reg[i]) low_idx = REG_ADDR_W'(i);
    end
  end

`ifdef LSM_BASE_WRITEBACK_EN
  // Set at accept time when the base is reloaded from memory; the write-back
  // must not overwrite the loaded value.
  logic wb_skip_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wb_skip_reg <= 1'b0;
    end else if (accept) begin
      wb_skip_reg <= is_load_i & reg_list_i[base_reg_i];
    end
  end

  assign wb_pending  = ~wb_skip_reg;
  assign wb_valid_o  = (state_reg == ST_WB);
  assign wb_reg_o    = wb_valid_o ? base_reg : 3'd0;
  assign wb_offset_o = wb_valid_o ? count_bytes : '0;
`else
  logic unused_base;
  assign unused_base = ^base_reg;
  assign wb_pending  = 1'b0;
  assign wb_valid_o  = 1'b0;
  assign wb_reg_o    = 3'd0;
  assign wb_offset_o = '0;
`endif

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          mask_next  = reg_list_i;
          count_next = '0;
          state_next = (|reg_list_i) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (!hold_i) begin
          mask_next = mask_reg & (mask_reg - REG_LIST_W'(1));
          if (count_reg != CNT_MAX) count_next = count_reg + 4'd1;
          if (mask_last) state_next = wb_pending ? ST_WB : ST_DONE;
        end
      end
      ST_WB: begin
        if (!hold_i) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= ST_IDLE;
      mask_reg  <= '0;
      count_reg <= '0;
      load_reg  <= 1'b0;
      base_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      count_reg <= count_next;
      if (accept) begin
        load_reg <= is_load_i;
        base_reg <= base_reg_i;
      end
    end
  end

  // The stall drops in the same cycle as the final uop when nothing follows,
  // so that fetch resumes without a bubble.
  always_comb begin
    case (state_reg)
      ST_IDLE: stall_pipeline_o = start_i & (|reg_list_i);
      ST_XFER: stall_pipeline_o = ~(mask_last & ~hold_i & ~wb_pending);
      ST_WB:   stall_pipeline_o = hold_i;
      default: stall_pipeline_o = 1'b0;
    endcase
  end

  assign busy_o         = (state_reg != ST_IDLE);
  assign uop_valid_o    = in_xfer;
  assign uop_reg_addr_o = in_xfer ? low_idx : '0;
  assign uop_offset_o   = in_xfer ? count_bytes : '0;
  assign mem_write_en_o = in_xfer & ~load_reg;
  assign reg_write_en_o = in_xfer & load_reg;
  assign done_o         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_load_store_mult_sequencer.sv
module tb_load_store_mult_sequencer;

`ifdef LSM_BASE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b0;
  logic       start = 1'b0, load = 1'b0, hold = 1'b0;
  logic [7:0] list = 8'h00;
  logic [2:0] base = 3'd0;

  logic       busy, stall, uop_valid, mem_we, reg_we, wb_valid, done;
  logic [3:0] uop_reg_addr;
  logic [5:0] uop_offset, wb_offset;
  logic [2:0] wb_reg;

  load_store_mult_sequencer dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .is_load_i(load),
    .reg_list_i(list), .base_reg_i(base), .hold_i(hold),
    .busy_o(busy), .stall_pipeline_o(stall), .uop_valid_o(uop_valid),
    .uop_reg_addr_o(uop_reg_addr), .uop_offset_o(uop_offset),
    .mem_write_en_o(mem_we), .reg_write_en_o(reg_we),
    .wb_valid_o(wb_valid), .wb_reg_o(wb_reg), .wb_offset_o(wb_offset),
    .done_o(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: the pending register numbers sit in a queue,
  // and a few flags mark the write-back and done phases.
  int m_q[$];
  int m_n = 0;
  int m_base = 0;
  bit m_wb = 0, m_done = 0, m_load = 0, m_wb_app = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_n = 0; m_wb = 0; m_done = 0; m_load = 0; m_base = 0; m_wb_app = 0;
    end else if (m_q.size() > 0) begin
      if (!hold) begin
        void'(m_q.pop_front());
        m_n++;
        if (m_q.size() == 0) begin
          if (m_wb_app) m_wb = 1; else m_done = 1;
        end
      end
    end else if (m_wb) begin
      if (!hold) begin m_wb = 0; m_done = 1; end
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_load = load; m_base = int'(base); m_n = 0;
      m_wb_app = WB_EN && !(load && list[base]);
      for (int i = 0; i < 8; i++) if (list[i]) m_q.push_back(i);
      if (m_q.size() == 0) m_done = 1;
    end
  end

  always @(negedge clk) begin : compare
    bit uv, wbv, idle, e_stall;
    uv   = (m_q.size() > 0);
    wbv  = !uv && m_wb;
    idle = !uv && !m_wb && !m_done;
    if (idle)     e_stall = start && (list != 8'h00);
    else if (uv)  e_stall = !(m_q.size() == 1 && !hold && !m_wb_app);
    else if (wbv) e_stall = hold;
    else          e_stall = 1'b0;
    chk("m_busy", busy, !idle);
    chk("m_stall", stall, e_stall);
    chk("m_uop_valid", uop_valid, uv);
    chk("m_uop_reg", uop_reg_addr, uv ? m_q[0] : 0);
    chk("m_uop_off", uop_offset, uv ? 4 * m_n : 0);
    chk("m_mem_we", mem_we, uv && !m_load);
    chk("m_reg_we", reg_we, uv && m_load);
    chk("m_wb_valid", wb_valid, wbv);
    chk("m_wb_reg", wb_reg, wbv ? m_base : 0);
    chk("m_wb_off", wb_offset, wbv ? 4 * m_n : 0);
    chk("m_done", done, !uv && !m_wb && m_done);
  end

  int t1_regs[4] = '{0, 2, 5, 7};

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_uop_valid", uop_valid, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // STM r0,r2,r5,r7
    start = 1; list = 8'hA5; load = 0; base = 3'd3;
    @(negedge clk); chk("t1_accept_stall", stall, 1);
    step(); start = 0; list = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_reg", uop_reg_addr, t1_regs[k]);
      chk("t1_off", uop_offset, 4 * k);
      chk("t1_mem_we", mem_we, 1);
      chk("t1_stall", stall, (k < 3) || WB_EN);
      step();
    end
    @(negedge clk);
    chk("t1_wb_valid", wb_valid, WB_EN);
    chk("t1_wb_reg", wb_reg, WB_EN ? 3 : 0);
    chk("t1_wb_off", wb_offset, WB_EN ? 16 : 0);
    chk("t1_done_a", done, !WB_EN);
    step();
    @(negedge clk); chk("t1_done_b", done, WB_EN);
    step(); step();

    // LDM {r0}, base r1
    start = 1; list = 8'h01; load = 1; base = 3'd1;
    step(); start = 0;
    @(negedge clk);
    chk("t2_reg", uop_reg_addr, 0);
    chk("t2_reg_we", reg_we, 1);
    chk("t2_stall", stall, WB_EN);
    step();
    @(negedge clk);
    chk("t2_wb_valid", wb_valid, WB_EN);
    chk("t2_wb_reg", wb_reg, WB_EN ? 1 : 0);
    chk("t2_wb_off", wb_offset, WB_EN ? 4 : 0);
    chk("t2_done_a", done, !WB_EN);
    step();
    @(negedge clk); chk("t2_done_b", done, WB_EN);
    step(); step();

    // LDM {r1,r7}, base r7: write-back never happens
    start = 1; list = 8'h82; load = 1; base = 3'd7;
    step(); start = 0;
    @(negedge clk); chk("t3_reg0", uop_reg_addr, 1);
    step();
    @(negedge clk); chk("t3_reg1", uop_reg_addr, 7); chk("t3_stall", stall, 0);
    step();
    @(negedge clk); chk("t3_done", done, 1); chk("t3_wb_valid", wb_valid, 0);
    step();

    // Hold during the second uop of {r1,r2,r3}
    start = 1; list = 8'h0E; load = 0; base = 3'd0;
    step(); start = 0;
    @(negedge clk); chk("t4_reg0", uop_reg_addr, 1);
    step(); hold = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_reg", uop_reg_addr, 2);
      chk("t4_hold_off", uop_offset, 4);
      chk("t4_hold_stall", stall, 1);
      step();
    end
    hold = 0;
    @(negedge clk); chk("t4_rel_reg", uop_reg_addr, 2); chk("t4_rel_off", uop_offset, 4);
    step();
    @(negedge clk); chk("t4_reg2", uop_reg_addr, 3); chk("t4_off2", uop_offset, 8);
    step(); step(); step();

    // Empty list
    start = 1; list = 8'h00; load = 0;
    @(negedge clk); chk("t5_stall", stall, 0);
    step(); start = 0;
    @(negedge clk); chk("t5_done", done, 1); chk("t5_uop_valid", uop_valid, 0);
    step();

    // Asynchronous reset after r3 of a full list
    start = 1; list = 8'hFF; load = 1; base = 3'd2;
    step(); start = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t6_reg", uop_reg_addr, k);
      if (k < 3) step();
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_uop_valid", uop_valid, 0);
    chk("t6_rst_reg", uop_reg_addr, 0);
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_reg_we", reg_we, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("t6_no_done", done, 0);
    start = 1; list = 8'hFF; load = 0;
    step(); start = 0;
    @(negedge clk); chk("t6_restart_reg", uop_reg_addr, 0); chk("t6_restart_off", uop_offset, 0);
    repeat (12) step();

    // Randomized traffic; checked every cycle by the model
    for (int c = 0; c < 2500; c++) begin
      start = ($urandom_range(0, 2) == 0);
      list  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      load  = 1'($urandom);
      base  = 3'($urandom);
      hold  = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 0; hold = 0;
    repeat (40) step();
    @(negedge clk); chk("end_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
